// File: rtl/adc_seq_pkg.sv
// Shared state encoding, SPI command codes and status-byte layout for the slope ADC sequencer.
package adc_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SHORT   = 3'd1,
        ST_RUNUP   = 3'd2,
        ST_RUNDOWN = 3'd3,
        ST_LATCH   = 3'd4
    } state_t;

    localparam logic [7:0] CMD_START   = 8'hCC;
    localparam logic [7:0] CMD_CONT    = 8'hCD;
    localparam logic [7:0] CMD_ABORT   = 8'hCE;
    localparam logic [7:0] CMD_WR_TRST = 8'h10;
    localparam logic [7:0] CMD_WR_TINT = 8'h11;
    localparam logic [7:0] CMD_WR_TTMO = 8'h12;
    localparam logic [7:0] CMD_NOP     = 8'h00;

    localparam int STS_DRDY     = 7;
    localparam int STS_OVR      = 6;
    localparam int STS_TMO      = 5;
    localparam int STS_BUSY     = 4;
    localparam int STS_STATE_LO = 1;
    localparam int STS_CONT     = 0;

    function automatic logic is_write(input logic [7:0] c);
        return (c == CMD_WR_TRST) || (c == CMD_WR_TINT) || (c == CMD_WR_TTMO);
    endfunction

endpackage

// File: rtl/adc_spi_frame.sv
// SPI mode-0 slave front end: synchronisers, command/data capture, MISO shifter, frame-length tracking.
// cmd_valid 1 clk after the synchronised decisive sck edge; no backpressure, commands are one-cycle strobes.
module adc_spi_frame
    import adc_seq_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sck,
    input  logic             ssel,
    input  logic             mosi,
    input  logic             t_trigger,
    input  logic [7:0]       status,
    input  logic [CNT_W-1:0] result,
    output logic             miso,
    output logic             cmd_valid,
    output logic [7:0]       cmd,
    output logic [CNT_W-1:0] wdata,
    output logic             read_ack,
    output logic             trig_rise
);
    localparam int FW = 8 + CNT_W;
    localparam int BW = $clog2(FW + 1);
    localparam logic [BW-1:0] CMD_LAST = BW'(7);
    localparam logic [BW-1:0] DAT_LAST = BW'(FW - 1);
    localparam logic [BW-1:0] FULL     = BW'(FW);

    logic [2:0]       sck_q, ssel_q, trig_q;
    logic [1:0]       mosi_q;
    logic [BW-1:0]    bit_cnt;
    logic [7:0]       cmd_sh;
    logic [CNT_W-1:0] dat_sh;
    logic [FW-1:0]    tx_sh;
    logic             sck_rise, sck_fall, ssel_rise, ssel_fall, mosi_s;
    logic [7:0]       cmd_byte;

    // bit [1] is the synchronised level, bit [2] its previous value for edge detection
    assign sck_rise  = sck_q[1] & ~sck_q[2];
    assign sck_fall  = ~sck_q[1] & sck_q[2];
    assign ssel_fall = ~ssel_q[1] & ssel_q[2];
    assign ssel_rise = ssel_q[1] & ~ssel_q[2];
    assign mosi_s    = mosi_q[1];
    assign cmd_byte  = {cmd_sh[6:0], mosi_s};
    assign miso      = tx_sh[FW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q     <= 3'b000;
            ssel_q    <= 3'b111;
            trig_q    <= 3'b000;
            mosi_q    <= 2'b00;
            bit_cnt   <= '0;
            cmd_sh    <= '0;
            dat_sh    <= '0;
            tx_sh     <= '0;
            cmd_valid <= 1'b0;
            cmd       <= '0;
            wdata     <= '0;
            read_ack  <= 1'b0;
            trig_rise <= 1'b0;
        end else begin
            sck_q     <= {sck_q[1:0], sck};
            ssel_q    <= {ssel_q[1:0], ssel};
            trig_q    <= {trig_q[1:0], t_trigger};
            mosi_q    <= {mosi_q[0], mosi};
            trig_rise <= trig_q[1] & ~trig_q[2];
            cmd_valid <= 1'b0;
            read_ack  <= 1'b0;
            if (ssel_fall) begin
                bit_cnt <= '0;
                tx_sh   <= {status, result};
            end else if (ssel_rise) begin
                read_ack <= (bit_cnt == FULL);
            end else if (!ssel_q[1]) begin
                if (sck_rise) begin
                    if (bit_cnt != FULL) bit_cnt <= bit_cnt + BW'(1);
                    if (bit_cnt <= CMD_LAST) cmd_sh <= cmd_byte;
                    else                     dat_sh <= {dat_sh[CNT_W-2:0], mosi_s};
                    if (bit_cnt == CMD_LAST && !is_write(cmd_byte)) begin
                        cmd_valid <= 1'b1;
                        cmd       <= cmd_byte;
                    end
                    if (bit_cnt == DAT_LAST && is_write(cmd_sh)) begin
                        cmd_valid <= 1'b1;
                        cmd       <= cmd_sh;
                        wdata     <= {dat_sh[CNT_W-2:0], mosi_s};
                    end
                end
                if (sck_fall) tx_sh <= {tx_sh[FW-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/adc_slope_sequencer.sv
// Dual-slope ADC conversion sequencer: SPI-programmed phase timing, rundown counter, status flags.
// Commands act 1 clk after the SPI strobe; no backpressure, overrun flags results not read in time.
module adc_slope_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int T_RESET_DEF = 1000,
    parameter int T_INT_DEF   = 1000000,
    parameter int T_TMO_DEF   = 4000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck,
    input  logic ssel,
    input  logic mosi,
    output logic miso,
    input  logic t_trigger,
    output logic m_reset,
    output logic m_in,
    output logic m_ref,
    output logic busy,
    output logic data_ready
);
    localparam logic [CNT_W-1:0] RST_DEF = CNT_W'(T_RESET_DEF);
    localparam logic [CNT_W-1:0] INT_DEF = CNT_W'(T_INT_DEF);
    localparam logic [CNT_W-1:0] TMO_DEF = CNT_W'(T_TMO_DEF);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] t_reset, t_int, t_tmo, sh_reset, sh_int, sh_tmo, cnt, result, wdata;
    logic             cont, overrun, timeout, cmd_valid, read_ack, trig_rise;
    logic [7:0]       cmd, status;

    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    always_comb begin
        status                       = '0;
        status[STS_DRDY]             = data_ready;
        status[STS_OVR]              = overrun;
        status[STS_TMO]              = timeout;
        status[STS_BUSY]             = busy;
        status[STS_STATE_LO +: 3]    = state;
        status[STS_CONT]             = cont;
    end

    assign m_ref = ~m_in;

    adc_spi_frame #(.CNT_W(CNT_W)) u_spi (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck       (sck),
        .ssel      (ssel),
        .mosi      (mosi),
        .t_trigger (t_trigger),
        .status    (status),
        .result    (result),
        .miso      (miso),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .wdata     (wdata),
        .read_ack  (read_ack),
        .trig_rise (trig_rise)
    );

    // Later assignments win: LATCH/timeout set beats a read clear, a command beats the phase sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            m_reset    <= 1'b0;
            m_in       <= 1'b1;
            busy       <= 1'b0;
            cont       <= 1'b0;
            cnt        <= '0;
            result     <= '0;
            data_ready <= 1'b0;
            overrun    <= 1'b0;
            timeout    <= 1'b0;
            t_reset    <= RST_DEF;
            t_int      <= INT_DEF;
            t_tmo      <= TMO_DEF;
            sh_reset   <= RST_DEF;
            sh_int     <= INT_DEF;
            sh_tmo     <= TMO_DEF;
        end else begin
            if (read_ack) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
                timeout    <= 1'b0;
            end
            case (state)
                ST_SHORT: begin
                    if (cnt >= sh_reset) begin
                        state   <= ST_RUNUP;
                        m_reset <= 1'b1;
                        m_in    <= 1'b0;
                        cnt     <= ONE;
                    end else cnt <= cnt + ONE;
                end
                ST_RUNUP: begin
                    if (cnt >= sh_int) begin
                        state <= ST_RUNDOWN;
                        m_in  <= 1'b1;
                        cnt   <= '0;
                    end else cnt <= cnt + ONE;
                end
                ST_RUNDOWN: begin
                    if (trig_rise) begin
                        state  <= ST_LATCH;
                        result <= cnt;
                    end else if (cnt >= sh_tmo) begin
                        state   <= ST_LATCH;
                        result  <= '1;
                        timeout <= 1'b1;
                    end else if (cnt != '1) cnt <= cnt + ONE;
                end
                ST_LATCH: begin
                    data_ready <= 1'b1;
                    overrun    <= overrun | data_ready;
                    if (cont) begin
                        state    <= ST_SHORT;
                        m_reset  <= 1'b0;
                        cnt      <= ONE;
                        sh_reset <= nz(t_reset);
                        sh_int   <= nz(t_int);
                        sh_tmo   <= nz(t_tmo);
                    end else begin
                        state   <= ST_IDLE;
                        m_reset <= 1'b0;
                        busy    <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (cmd_valid) begin
                case (cmd)
                    CMD_START, CMD_CONT: begin
                        state    <= ST_SHORT;
                        m_reset  <= 1'b0;
                        m_in     <= 1'b1;
                        busy     <= 1'b1;
                        cont     <= (cmd == CMD_CONT);
                        cnt      <= ONE;
                        sh_reset <= nz(t_reset);
                        sh_int   <= nz(t_int);
                        sh_tmo   <= nz(t_tmo);
                    end
                    CMD_ABORT: begin
                        state   <= ST_IDLE;
                        m_reset <= 1'b0;
                        m_in    <= 1'b1;
                        busy    <= 1'b0;
                        cont    <= 1'b0;
                    end
                    CMD_WR_TRST: t_reset <= wdata;
                    CMD_WR_TINT: t_int   <= wdata;
                    CMD_WR_TTMO: t_tmo   <= wdata;
                    CMD_NOP: ;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_slope_sequencer.sv
// Self-checking bench: table of conversions plus hand sequences for continuous, restart and reset cases.
`timescale 1ns/1ps
module tb_adc_slope_sequencer;
    localparam int HP = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sck = 1'b0, ssel = 1'b1, mosi = 1'b0, t_trigger = 1'b0;
    logic miso, m_reset, m_in, m_ref, busy, data_ready;

    int checks = 0, failures = 0;
    int short_len = 0, runup_len = 0, sc = 0, rc = 0, rdc = 0, latch_cnt = 0;
    int trig_delay = -1;
    logic in_rd_q = 1'b0;

    typedef struct {
        logic [7:0]  st;
        logic [31:0] res;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          wr;
        logic [31:0] trst, tint, ttmo;
        int          trig;
        int          exp_short, exp_runup;
        logic [7:0]  exp_st;
        logic [31:0] exp_res;
    } vec_t;
    vec_t vecs[8];

    always #5 clk = ~clk;

    adc_slope_sequencer #(
        .CNT_W(32), .T_RESET_DEF(200), .T_INT_DEF(1500), .T_TMO_DEF(4000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .ssel(ssel), .mosi(mosi), .miso(miso),
        .t_trigger(t_trigger), .m_reset(m_reset), .m_in(m_in), .m_ref(m_ref),
        .busy(busy), .data_ready(data_ready)
    );

    // Phase-length monitor and comparator model: trigger rises trig_delay clocks into RUNDOWN.
    always @(negedge clk) begin
        logic in_rd;
        in_rd = busy && m_reset && m_in;
        if (busy && !m_reset) sc++;
        else if (sc != 0) begin short_len = sc; sc = 0; end
        if (busy && !m_in) rc++;
        else if (rc != 0) begin runup_len = rc; rc = 0; end
        if (in_rd === 1'b1) begin
            rdc = in_rd_q ? rdc + 1 : 0;
            if (trig_delay >= 0 && rdc == trig_delay) t_trigger = 1'b1;
        end else begin
            t_trigger = 1'b0;
            if (in_rd_q) latch_cnt++;
        end
        in_rd_q = (in_rd === 1'b1);
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input logic [7:0] c, input logic [31:0] d, input int nbits,
                             output logic [39:0] rx);
        logic [39:0] tx;
        tx = {c, d};
        rx = '0;
        ssel = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[39-i];
            repeat (HP) @(negedge clk);
            rx[39-i] = miso;
            sck = 1'b1;
            repeat (HP) @(negedge clk);
            sck = 1'b0;
        end
        repeat (HP) @(negedge clk);
        ssel = 1'b1;
        mosi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] c, input logic [31:0] v);
        logic [39:0] rx;
        spi_frame(c, v, 40, rx);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        logic [39:0] rx;
        spi_frame(c, 32'h0, 8, rx);
    endtask

    task automatic expect_read(input logic [7:0] st, input logic [31:0] res);
        exp_t e;
        e.st = st;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic read_check(input string name);
        logic [39:0] rx;
        exp_t e;
        spi_frame(8'h00, 32'h0, 40, rx);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, rx);
        end else begin
            e = sb.pop_front();
            check({name, " status"}, {32'h0, rx[39:32]}, {32'h0, e.st});
            check({name, " result"}, {8'h0, rx[31:0]}, {8'h0, e.res});
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 20000) begin @(negedge clk); n++; end
        check({name, " idle"}, {39'h0, busy}, 40'h0);
    endtask

    task automatic wait_runup(input string name);
        int n = 0;
        while (!(busy === 1'b1 && m_in === 1'b0) && n < 20000) begin @(negedge clk); n++; end
        check({name, " runup"}, {39'h0, m_in}, 40'h0);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        if (v.wr) begin
            wr_reg(8'h10, v.trst);
            wr_reg(8'h11, v.tint);
            wr_reg(8'h12, v.ttmo);
        end
        trig_delay = v.trig;
        expect_read(v.exp_st, v.exp_res);
        send_cmd(8'hCC);
        wait_idle(name);
        check({name, " short_len"}, 40'(short_len), 40'(v.exp_short));
        check({name, " runup_len"}, 40'(runup_len), 40'(v.exp_runup));
        check({name, " data_ready"}, {39'h0, data_ready}, 40'h1);
        read_check(name);
        check({name, " ready cleared"}, {39'h0, data_ready}, 40'h0);
    endtask

    task automatic check_idle_pins(input string name, input logic exp_dr, input bit chk_miso);
        check({name, " m_reset"}, {39'h0, m_reset}, 40'h0);
        check({name, " m_in"}, {39'h0, m_in}, 40'h1);
        check({name, " m_ref"}, {39'h0, m_ref}, 40'h0);
        check({name, " busy"}, {39'h0, busy}, 40'h0);
        check({name, " data_ready"}, {39'h0, data_ready}, {39'h0, exp_dr});
        if (chk_miso) check({name, " miso"}, {39'h0, miso}, 40'h0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int lc0;
        //          wr  trst   tint    ttmo     trig short runup status  result
        vecs[0] = '{1'b0, 32'd0, 32'd0,  32'd0,    500, 200, 1500, 8'h80, 32'd503};
        vecs[1] = '{1'b1, 32'd4, 32'd10, 32'd1000, 20,  4,   10,   8'h80, 32'd23};
        vecs[2] = '{1'b1, 32'd0, 32'd0,  32'd1000, 7,   1,   1,    8'h80, 32'd10};
        vecs[3] = '{1'b1, 32'd3, 32'd5,  32'd50,   -1,  3,   5,    8'hA0, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'd3, 32'd5,  32'd50,   46,  3,   5,    8'h80, 32'd49};
        vecs[5] = '{1'b1, 32'd3, 32'd5,  32'd50,   48,  3,   5,    8'hA0, 32'hFFFF_FFFF};
        vecs[6] = '{1'b1, 32'd2, 32'd2,  32'd0,    -1,  2,   2,    8'hA0, 32'hFFFF_FFFF};
        vecs[7] = '{1'b1, 32'd6, 32'd12, 32'd50,   0,   6,   12,   8'h80, 32'd3};

        #3 rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check_idle_pins("reset", 1'b0, 1'b1);

        for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // continuous mode: two unread results must raise overrun; abort keeps data_ready
        wr_reg(8'h10, 32'd3);
        wr_reg(8'h11, 32'd5);
        wr_reg(8'h12, 32'd1000);
        trig_delay = 10;
        lc0 = latch_cnt;
        send_cmd(8'hCD);
        for (int n = 0; n < 5000 && latch_cnt < lc0 + 2; n++) @(negedge clk);
        check("cont two latches", {39'h0, latch_cnt >= lc0 + 2}, 40'h1);
        send_cmd(8'hCE);
        check_idle_pins("abort", 1'b1, 1'b0);
        expect_read(8'hC0, 32'd13);
        read_check("cont");
        check("cont ready cleared", {39'h0, data_ready}, 40'h0);

        // shadow registers: a t_int write during RUNUP applies to the next conversion only
        wr_reg(8'h10, 32'd5);
        wr_reg(8'h11, 32'd2000);
        wr_reg(8'h12, 32'd1000);
        trig_delay = 10;
        expect_read(8'h80, 32'd13);
        send_cmd(8'hCC);
        wait_runup("shadow");
        wr_reg(8'h11, 32'd40);
        wait_idle("shadow");
        check("shadow runup_len", 40'(runup_len), 40'd2000);
        read_check("shadow");

        // restart mid-RUNUP: back to SHORT, previous result still readable
        wr_reg(8'h11, 32'd2000);
        send_cmd(8'hCC);
        wait_runup("restart");
        send_cmd(8'hCC);
        expect_read(8'h14, 32'd13);
        read_check("restart mid");
        expect_read(8'h80, 32'd13);
        wait_idle("restart");
        check("restart short_len", 40'(short_len), 40'd5);
        check("restart runup_len", 40'(runup_len), 40'd2000);
        read_check("restart done");

        // asynchronous reset in RUNDOWN, then a conversion on the default timing
        wr_reg(8'h10, 32'd3);
        wr_reg(8'h11, 32'd5);
        wr_reg(8'h12, 32'd3000);
        trig_delay = -1;
        send_cmd(8'hCC);
        for (int n = 0; n < 2000 && !(busy === 1'b1 && m_reset === 1'b1 && m_in === 1'b1); n++)
            @(negedge clk);
        check("arst in rundown", {39'h0, busy && m_reset && m_in}, 40'h1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle_pins("arst", 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        v = vecs[0];
        v.trig = 100;
        v.exp_res = 32'd103;
        run_vec(v, "post-reset defaults");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
